load_store_unit: RTL and testbench

Parametrised successor to the single-cycle load/store block. It adds a valid/ready request and response handshake, byte/halfword/word access with sign or zero extension, misalignment detection, a configurable memory depth and a configurable response latency. It sits in the EX/MEM boundary of the core and owns a private word-organised data memory.

---
 rtl/load_store_unit.sv | 142 ++++++++++++++
 tb/tb_load_store_unit.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit with a private little-endian word memory, sub-word access and alignment faults.
// Latency: LATENCY cycles from request acceptance to response (one request per cycle unstalled).
// Backpressure: a held response (resp_valid && !resp_ready) freezes the pipeline and drops req_ready.
module load_store_unit #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] base,
  input  logic [31:0] offset,
  input  logic [31:0] data,
  input  logic        store,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] result,
  output logic        misaligned
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  logic [31:0]           addr;
  logic [DEPTH_LOG2-1:0] widx;
  logic [1:0]            lane;
  logic [31:0]           scramble;
  logic [31:0]           cur_word;
  logic                  fault;
  logic                  advance;
  logic                  accept;
  logic                  wr_en;
  logic [31:0]           wr_lanes;
  logic [3:0]            wr_be;
  logic [31:0]           new_word;
  logic [15:0]           ld_half;
  logic [7:0]            ld_byte;
  logic [31:0]           ld_data;
  logic [31:0]           new_res;
  logic                  unused_addr;

  // Words are stored XOR'd with their own index, so a zero-filled array
  // reads back as word i = i without any power-up initialisation pass.
  logic [31:0] mem [DEPTH];

  logic [LATENCY-1:0] stg_vld;
  logic [LATENCY-1:0] stg_mis;
  logic [31:0]        stg_res [LATENCY];

  assign addr        = base + offset;
  assign widx        = addr[DEPTH_LOG2+1:2];
  assign lane        = addr[1:0];
  assign scramble    = {{(32-DEPTH_LOG2){1'b0}}, widx};
  assign cur_word    = mem[widx] ^ scramble;
  assign unused_addr = &{1'b0, addr[31:DEPTH_LOG2+2]};

  // Stall only when a response is presented and not taken; reset blocks acceptance.
  assign advance   = !(resp_valid && !resp_ready);
  assign req_ready = advance && !rst;
  assign accept    = req_valid && req_ready;
  assign wr_en     = accept && store && !fault;

  // Alignment and size fault detection.
  always_comb begin
    fault = 1'b0;
    case (size)
      SZ_BYTE: fault = 1'b0;
      SZ_HALF: fault = lane[0];
      SZ_WORD: fault = (lane != 2'b00);
      default: fault = 1'b1;
    endcase
  end

  // Replicate store data across lanes and merge the enabled lanes into the current word.
  always_comb begin
    wr_lanes = data;
    wr_be    = 4'b0000;
    case (size)
      SZ_BYTE: begin
        wr_lanes = {4{data[7:0]}};
        wr_be    = 4'b0001 << lane;
      end
      SZ_HALF: begin
        wr_lanes = {2{data[15:0]}};
        wr_be    = lane[1] ? 4'b1100 : 4'b0011;
      end
      SZ_WORD: wr_be = 4'b1111;
      default: wr_be = 4'b0000;
    endcase
    new_word = cur_word;
    for (int b = 0; b < 4; b++) begin
      if (wr_be[b]) new_word[8*b +: 8] = wr_lanes[8*b +: 8];
    end
  end

  // Select the addressed lane(s) and extend; word loads pass straight through.
  always_comb begin
    ld_half = lane[1] ? cur_word[31:16] : cur_word[15:0];
    ld_byte = lane[0] ? ld_half[15:8] : ld_half[7:0];
    ld_data = cur_word;
    case (size)
      SZ_BYTE: ld_data = unsigned_ld ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      SZ_HALF: ld_data = unsigned_ld ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_data = cur_word;
    endcase
    new_res = (store || fault) ? 32'h0 : ld_data;
  end

  // Memory write on the accepting edge; not reset so stores survive rst.
  always_ff @(posedge clk) begin
    if (wr_en) mem[widx] <= new_word ^ scramble;
  end

  // Response pipeline: all stages shift together on advance; bubbles enter as valid = 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_vld <= '0;
      stg_mis <= '0;
      for (int i = 0; i < LATENCY; i++) stg_res[i] <= '0;
    end else if (advance) begin
      stg_vld[0] <= accept;
      stg_mis[0] <= accept && fault;
      stg_res[0] <= accept ? new_res : 32'h0;
      for (int i = 1; i < LATENCY; i++) begin
        stg_vld[i] <= stg_vld[i-1];
        stg_mis[i] <= stg_mis[i-1];
        stg_res[i] <= stg_res[i-1];
      end
    end
  end

  assign resp_valid = stg_vld[LATENCY-1];
  assign misaligned = stg_mis[LATENCY-1];
  assign result     = stg_res[LATENCY-1];

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: three instances (LATENCY 1, LATENCY 3, small wrapping memory).
// Each scenario task drives requests and compares responses against hand-computed values.
// Inputs change #1 after the rising edge; outputs are sampled there as well.
module tb_load_store_unit;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_R = 2'b11;

  typedef struct packed {
    logic        st;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] b;
    logic [31:0] o;
    logic [31:0] d;
    logic        mis;
    logic [31:0] res;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic        req_valid   [3];
  logic        req_ready   [3];
  logic [31:0] base        [3];
  logic [31:0] offset      [3];
  logic [31:0] data        [3];
  logic        store       [3];
  logic [1:0]  size        [3];
  logic        unsigned_ld [3];
  logic        resp_valid  [3];
  logic        resp_ready  [3];
  logic [31:0] result      [3];
  logic        misaligned  [3];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  load_store_unit #(.DEPTH_LOG2(10), .LATENCY(1)) u_lat1 (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .base(base[0]), .offset(offset[0]), .data(data[0]), .store(store[0]),
    .size(size[0]), .unsigned_ld(unsigned_ld[0]), .resp_valid(resp_valid[0]),
    .resp_ready(resp_ready[0]), .result(result[0]), .misaligned(misaligned[0])
  );

  load_store_unit #(.DEPTH_LOG2(10), .LATENCY(3)) u_lat3 (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .base(base[1]), .offset(offset[1]), .data(data[1]), .store(store[1]),
    .size(size[1]), .unsigned_ld(unsigned_ld[1]), .resp_valid(resp_valid[1]),
    .resp_ready(resp_ready[1]), .result(result[1]), .misaligned(misaligned[1])
  );

  load_store_unit #(.DEPTH_LOG2(4), .LATENCY(2)) u_small (
    .clk(clk), .rst(rst), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .base(base[2]), .offset(offset[2]), .data(data[2]), .store(store[2]),
    .size(size[2]), .unsigned_ld(unsigned_ld[2]), .resp_valid(resp_valid[2]),
    .resp_ready(resp_ready[2]), .result(result[2]), .misaligned(misaligned[2])
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int d, input logic st, input logic [1:0] sz, input logic uns,
                       input logic [31:0] b, input logic [31:0] o, input logic [31:0] dat);
    req_valid[d]   = 1'b1;
    store[d]       = st;
    size[d]        = sz;
    unsigned_ld[d] = uns;
    base[d]        = b;
    offset[d]      = o;
    data[d]        = dat;
    #1;
  endtask

  task automatic idle(input int d);
    req_valid[d] = 1'b0;
    store[d]     = 1'b0;
    base[d]      = 32'h0;
    offset[d]    = 32'h0;
    data[d]      = 32'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if ({req_ready[d], resp_valid[d], misaligned[d], result[d]} !== 35'h0) begin
        errors++;
        $display("FAIL reset_state dut%0d: got rdy=%b vld=%b mis=%b res=%h, expected all 0",
                 d, req_ready[d], resp_valid[d], misaligned[d], result[d]);
      end
    end
    step();
    step();
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b, expected 1", req_ready[0]);
    end
  endtask

  task automatic test_load_sweep();
    for (int k = 0; k < 12; k++) begin
      issue(0, 1'b0, SZ_W, 1'b0, 32'(4 * k), 32'h0, 32'h0);
      checks++;
      if (req_ready[0] !== 1'b1) begin
        errors++;
        $display("FAIL sweep_ready[%0d]: got %b, expected 1", k, req_ready[0]);
      end
      step();
      checks++;
      if ({resp_valid[0], misaligned[0], result[0]} !== {1'b1, 1'b0, 32'(k)}) begin
        errors++;
        $display("FAIL sweep_data[%0d]: got vld=%b mis=%b res=%h, expected vld=1 mis=0 res=%h",
                 k, resp_valid[0], misaligned[0], result[0], 32'(k));
      end
    end
    idle(0);
    step();
    checks++;
    if (resp_valid[0] !== 1'b0) begin
      errors++;
      $display("FAIL sweep_bubble: got resp_valid=%b, expected 0", resp_valid[0]);
    end
  endtask

  task automatic test_round_trip();
    issue(0, 1'b1, SZ_W, 1'b0, 32'h40, 32'h4, 32'hDEADBEEF);
    step();
    checks++;
    if ({resp_valid[0], misaligned[0], result[0]} !== {1'b1, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL rt_store_resp: got vld=%b mis=%b res=%h, expected vld=1 mis=0 res=0",
               resp_valid[0], misaligned[0], result[0]);
    end
    issue(0, 1'b0, SZ_W, 1'b0, 32'h40, 32'h4, 32'h0);
    step();
    checks++;
    if ({resp_valid[0], misaligned[0], result[0]} !== {1'b1, 1'b0, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL rt_load: got vld=%b mis=%b res=%h, expected vld=1 mis=0 res=deadbeef",
               resp_valid[0], misaligned[0], result[0]);
    end
    idle(0);
    step();
  endtask

  task automatic test_subword();
    vec_t tbl [8];
    tbl[0] = '{1'b1, SZ_W, 1'b0, 32'h40, 32'h0, 32'hDEADBEEF, 1'b0, 32'h00000000};
    tbl[1] = '{1'b0, SZ_B, 1'b0, 32'h40, 32'h3, 32'h0,        1'b0, 32'hFFFFFFDE};
    tbl[2] = '{1'b0, SZ_B, 1'b1, 32'h40, 32'h3, 32'h0,        1'b0, 32'h000000DE};
    tbl[3] = '{1'b0, SZ_H, 1'b0, 32'h40, 32'h0, 32'h0,        1'b0, 32'hFFFFBEEF};
    tbl[4] = '{1'b0, SZ_H, 1'b1, 32'h40, 32'h2, 32'h0,        1'b0, 32'h0000DEAD};
    tbl[5] = '{1'b1, SZ_B, 1'b0, 32'h40, 32'h1, 32'hFFFFFF11, 1'b0, 32'h00000000};
    tbl[6] = '{1'b0, SZ_W, 1'b1, 32'h40, 32'h0, 32'h0,        1'b0, 32'hDEAD11EF};
    tbl[7] = '{1'b0, SZ_B, 1'b0, 32'h40, 32'h0, 32'h0,        1'b0, 32'hFFFFFFEF};
    for (int i = 0; i < 8; i++) begin
      issue(0, tbl[i].st, tbl[i].sz, tbl[i].uns, tbl[i].b, tbl[i].o, tbl[i].d);
      step();
      checks++;
      if ({resp_valid[0], misaligned[0], result[0]} !== {1'b1, tbl[i].mis, tbl[i].res}) begin
        errors++;
        $display("FAIL subword[%0d]: got vld=%b mis=%b res=%h, expected vld=1 mis=%b res=%h",
                 i, resp_valid[0], misaligned[0], result[0], tbl[i].mis, tbl[i].res);
      end
    end
    idle(0);
    step();
  endtask

  task automatic test_faults();
    vec_t tbl [8];
    tbl[0] = '{1'b0, SZ_W, 1'b0, 32'h40, 32'h2, 32'h0,        1'b1, 32'h0};
    tbl[1] = '{1'b0, SZ_H, 1'b0, 32'h40, 32'h1, 32'h0,        1'b1, 32'h0};
    tbl[2] = '{1'b0, SZ_R, 1'b0, 32'h40, 32'h0, 32'h0,        1'b1, 32'h0};
    tbl[3] = '{1'b1, SZ_W, 1'b0, 32'h40, 32'h2, 32'hFFFFFFFF, 1'b1, 32'h0};
    tbl[4] = '{1'b1, SZ_H, 1'b0, 32'h40, 32'h3, 32'hFFFFFFFF, 1'b1, 32'h0};
    tbl[5] = '{1'b1, SZ_R, 1'b0, 32'h40, 32'h0, 32'hFFFFFFFF, 1'b1, 32'h0};
    tbl[6] = '{1'b0, SZ_W, 1'b0, 32'h40, 32'h0, 32'h0,        1'b0, 32'hDEAD11EF};
    tbl[7] = '{1'b0, SZ_W, 1'b0, 32'hFFFFFFFC, 32'h44, 32'h0, 1'b0, 32'hDEAD11EF};
    for (int i = 0; i < 8; i++) begin
      issue(0, tbl[i].st, tbl[i].sz, tbl[i].uns, tbl[i].b, tbl[i].o, tbl[i].d);
      step();
      checks++;
      if ({resp_valid[0], misaligned[0], result[0]} !== {1'b1, tbl[i].mis, tbl[i].res}) begin
        errors++;
        $display("FAIL fault[%0d]: got vld=%b mis=%b res=%h, expected vld=1 mis=%b res=%h",
                 i, resp_valid[0], misaligned[0], result[0], tbl[i].mis, tbl[i].res);
      end
    end
    idle(0);
    step();
  endtask

  task automatic test_backpressure();
    resp_ready[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      issue(1, 1'b0, SZ_W, 1'b0, 32'h10, 32'(4 * k), 32'h0);
      checks++;
      if (req_ready[1] !== 1'b1) begin
        errors++;
        $display("FAIL bp_issue_ready[%0d]: got %b, expected 1", k, req_ready[1]);
      end
      step();
    end
    checks++;
    if ({resp_valid[1], misaligned[1], result[1]} !== {1'b1, 1'b0, 32'd4}) begin
      errors++;
      $display("FAIL bp_first: got vld=%b mis=%b res=%h, expected vld=1 mis=0 res=4",
               resp_valid[1], misaligned[1], result[1]);
    end
    resp_ready[1] = 1'b0;
    issue(1, 1'b0, SZ_W, 1'b0, 32'h10, 32'hC, 32'h0);
    for (int c = 0; c < 3; c++) begin
      checks++;
      if ({req_ready[1], resp_valid[1], misaligned[1], result[1]} !== {1'b0, 1'b1, 1'b0, 32'd4}) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got rdy=%b vld=%b mis=%b res=%h, expected rdy=0 vld=1 mis=0 res=4",
                 c, req_ready[1], resp_valid[1], misaligned[1], result[1]);
      end
      step();
    end
    resp_ready[1] = 1'b1;
    #1;
    checks++;
    if (req_ready[1] !== 1'b1) begin
      errors++;
      $display("FAIL bp_release_ready: got %b, expected 1", req_ready[1]);
    end
    step();
    idle(1);
    for (int k = 5; k < 8; k++) begin
      checks++;
      if ({resp_valid[1], misaligned[1], result[1]} !== {1'b1, 1'b0, 32'(k)}) begin
        errors++;
        $display("FAIL bp_drain[%0d]: got vld=%b mis=%b res=%h, expected vld=1 mis=0 res=%h",
                 k, resp_valid[1], misaligned[1], result[1], 32'(k));
      end
      step();
    end
    checks++;
    if (resp_valid[1] !== 1'b0) begin
      errors++;
      $display("FAIL bp_empty: got resp_valid=%b, expected 0", resp_valid[1]);
    end
  endtask

  task automatic test_wrap();
    issue(2, 1'b1, SZ_W, 1'b0, 32'h40, 32'h0, 32'hCAFEF00D);
    step();
    issue(2, 1'b0, SZ_W, 1'b0, 32'h0, 32'h0, 32'h0);
    step();
    idle(2);
    checks++;
    if ({resp_valid[2], misaligned[2], result[2]} !== {1'b1, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL wrap_store_resp: got vld=%b mis=%b res=%h, expected vld=1 mis=0 res=0",
               resp_valid[2], misaligned[2], result[2]);
    end
    step();
    checks++;
    if ({resp_valid[2], misaligned[2], result[2]} !== {1'b1, 1'b0, 32'hCAFEF00D}) begin
      errors++;
      $display("FAIL wrap_load: got vld=%b mis=%b res=%h, expected vld=1 mis=0 res=cafef00d",
               resp_valid[2], misaligned[2], result[2]);
    end
    step();
  endtask

  task automatic test_reset_midflight();
    issue(2, 1'b0, SZ_W, 1'b0, 32'h0, 32'h0, 32'h0);
    step();
    issue(2, 1'b0, SZ_W, 1'b0, 32'h4, 32'h0, 32'h0);
    step();
    idle(2);
    checks++;
    if ({resp_valid[2], result[2]} !== {1'b1, 32'hCAFEF00D}) begin
      errors++;
      $display("FAIL mid_inflight: got vld=%b res=%h, expected vld=1 res=cafef00d",
               resp_valid[2], result[2]);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({req_ready[2], resp_valid[2], misaligned[2], result[2]} !== 35'h0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got rdy=%b vld=%b mis=%b res=%h, expected all 0",
               req_ready[2], resp_valid[2], misaligned[2], result[2]);
    end
    step();
    step();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (resp_valid[2] !== 1'b0) begin
        errors++;
        $display("FAIL mid_no_stale[%0d]: got resp_valid=%b, expected 0", c, resp_valid[2]);
      end
    end
    issue(2, 1'b0, SZ_W, 1'b0, 32'h40, 32'h0, 32'h0);
    step();
    issue(2, 1'b0, SZ_W, 1'b0, 32'h4, 32'h0, 32'h0);
    step();
    idle(2);
    checks++;
    if ({resp_valid[2], misaligned[2], result[2]} !== {1'b1, 1'b0, 32'hCAFEF00D}) begin
      errors++;
      $display("FAIL mid_persist: got vld=%b mis=%b res=%h, expected vld=1 mis=0 res=cafef00d",
               resp_valid[2], misaligned[2], result[2]);
    end
    step();
    checks++;
    if ({resp_valid[2], misaligned[2], result[2]} !== {1'b1, 1'b0, 32'h1}) begin
      errors++;
      $display("FAIL mid_word1: got vld=%b mis=%b res=%h, expected vld=1 mis=0 res=1",
               resp_valid[2], misaligned[2], result[2]);
    end
    step();
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      idle(d);
      size[d]        = SZ_W;
      unsigned_ld[d] = 1'b0;
      resp_ready[d]  = 1'b1;
    end
    #1;
    test_reset();
    test_load_sweep();
    test_round_trip();
    test_subword();
    test_faults();
    test_backpressure();
    test_wrap();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
